// File: rtl/serializer_arbiter.sv
// serializer_arbiter
// Round-robin scheduler that lets N_REQ word sources share one serializer
// parallel input. A two-state FSM (IDLE/GRANT) picks a lane, the granted lane
// streams words into a registered output stage, and the serializer drains it.
// Optional feature: define ARB_BURST_EN to let a grant hold for up to
// MAX_BURST words. When it is undefined every grant carries exactly one word.
// busy_o mirrors the FSM state (1 = GRANT) for observation.
//
// Handshake semantics (both sides): a transfer happens on a rising clk edge
// where valid and ready are both high. Valid is never withdrawn by this block
// once raised on ser_valid_o, and ser_data_o stays stable until it transfers.
// req_ready_o is combinational and never depends on req_valid_i.

module serializer_arbiter #(
  parameter int N_REQ     = 4,
  parameter int WIDTH     = 16,
  parameter int LOG_N_REQ = 2,
  parameter int MAX_BURST = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ*WIDTH-1:0] req_data_i,
  input  logic [N_REQ-1:0]       req_valid_i,
  output logic [N_REQ-1:0]       req_ready_o,
  output logic [WIDTH-1:0]       ser_data_o,
  output logic                   ser_valid_o,
  input  logic                   ser_ready_i,
  output logic [LOG_N_REQ-1:0]   grant_o,
  output logic                   busy_o
);

  // Reject configurations the round-robin and burst logic cannot support.
  if (N_REQ < 2 || LOG_N_REQ != $clog2(N_REQ) || MAX_BURST < 1) begin : g_bad_cfg
    $error("serializer_arbiter: invalid parameter combination");
  end

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [LOG_N_REQ-1:0]   grant_q, grant_d;
  logic [LOG_N_REQ-1:0]   last_grant_q, last_grant_d;
  logic [WIDTH-1:0]       ser_data_q, ser_data_d;
  logic                   ser_valid_q, ser_valid_d;

  logic [WIDTH-1:0]       lane_word [N_REQ];
  logic [LOG_N_REQ-1:0]   rr_pick;
  logic [LOG_N_REQ-1:0]   cand;
  logic                   any_valid;
  logic                   gnt_valid;
  logic                   out_free;
  logic                   req_xfer;
  logic                   ser_xfer;
  logic                   burst_last;

`ifdef ARB_BURST_EN
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  // Grant ends on the transfer that completes the MAX_BURST-th word.
  assign burst_last = (burst_cnt_q == CNT_W'(MAX_BURST - 1));
`else
  // Strict one-word-per-grant round robin.
  assign burst_last = 1'b1;
`endif

  // Wrap-around increment of a lane index (N_REQ need not be a power of two).
  function automatic logic [LOG_N_REQ-1:0] next_lane(input logic [LOG_N_REQ-1:0] from);
    if (from == LOG_N_REQ'(N_REQ - 1)) begin
      return '0;
    end
    return from + 1'b1;
  endfunction

  // Unpack the flat requester bus into per-lane words.
  for (genvar g = 0; g < N_REQ; g++) begin : g_lane
    assign lane_word[g] = req_data_i[g*WIDTH +: WIDTH];
  end

  // Transfer qualifiers: the output register can take a word when it is empty
  // or is being drained in the same cycle.
  assign busy_o    = (state_q == ST_GRANT);
  assign grant_o   = grant_q;
  assign gnt_valid = req_valid_i[grant_q];
  assign out_free  = !ser_valid_q || ser_ready_i;
  assign req_xfer  = busy_o && out_free && gnt_valid;
  assign ser_xfer  = ser_valid_q && ser_ready_i;

  assign ser_data_o  = ser_data_q;
  assign ser_valid_o = ser_valid_q;

  // Per-lane ready: only the granted lane, only while the output can accept.
  always_comb begin
    req_ready_o = '0;
    if (busy_o && out_free) begin
      req_ready_o[grant_q] = 1'b1;
    end
  end

  // Round-robin search starting just after the last granted lane.
  always_comb begin
    rr_pick   = '0;
    any_valid = 1'b0;
    cand      = next_lane(last_grant_q);
    for (int k = 0; k < N_REQ; k++) begin
      if (!any_valid && req_valid_i[cand]) begin
        rr_pick   = cand;
        any_valid = 1'b1;
      end
      cand = next_lane(cand);
    end
  end

  // FSM next-state: arbitrate in IDLE, stream the granted lane in GRANT.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
`ifdef ARB_BURST_EN
    burst_cnt_d  = burst_cnt_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (any_valid) begin
          grant_d = rr_pick;
          state_d = ST_GRANT;
`ifdef ARB_BURST_EN
          burst_cnt_d = '0;
`endif
        end
      end
      ST_GRANT: begin
`ifdef ARB_BURST_EN
        if (req_xfer) begin
          burst_cnt_d = burst_cnt_q + 1'b1;
        end
`endif
        // A lane dropping valid forfeits the remainder of its burst.
        if (!gnt_valid || (req_xfer && burst_last)) begin
          state_d      = ST_IDLE;
          last_grant_d = grant_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output register next-state: a new word always wins over a plain drain,
  // so a simultaneous load and drain keeps valid high with the new word.
  always_comb begin
    ser_data_d  = ser_data_q;
    ser_valid_d = ser_valid_q;
    if (req_xfer) begin
      ser_data_d  = lane_word[grant_q];
      ser_valid_d = 1'b1;
    end else if (ser_xfer) begin
      ser_valid_d = 1'b0;
    end
  end

  // State and output registers; reset drops any pending word.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= LOG_N_REQ'(N_REQ - 1);
      ser_data_q   <= '0;
      ser_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      ser_data_q   <= ser_data_d;
      ser_valid_q  <= ser_valid_d;
    end
  end

`ifdef ARB_BURST_EN
  // Burst counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      burst_cnt_q <= '0;
    end else begin
      burst_cnt_q <= burst_cnt_d;
    end
  end
`endif

endmodule
